fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single write port of an asynchronous FIFO among NR requesters in the FIFO's write-clock domain. It grants one requester at a time, muxes that requester's data onto the FIFO write port, and gates every beat on the FIFO full flag. Optionally, a grant is held for a burst of up to BL beats. Placed directly in front of the FIFO write side; the FIFO write clock and write reset domain drive this block.

---
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NR requesters.
// Define FIFO_WR_ARB_BURST_EN to hold a grant for up to BL beats (or until I_LAST).
module fifo_wr_arbiter #(
    parameter int NR = 4,
    parameter int DW = 8,
    parameter int BL = 4
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic [NR-1:0]         I_REQ,
    input  logic [NR*DW-1:0]      I_DATA,
    input  logic [NR-1:0]         I_LAST,
    output logic [NR-1:0]         O_GNT,
    output logic [NR-1:0]         O_ACK,
    output logic [$clog2(NR)-1:0] O_OWNER,
    output logic                  O_BUSY,
    output logic                  O_WR_REQ,
    output logic [DW-1:0]         O_WR_DATA,
    input  logic                  I_WR_FULL
);
    localparam int OW = $clog2(NR);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [NR-1:0] gnt_q, gnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [OW-1:0] owner_inc;
    logic          pick_vld;
    logic [OW-1:0] pick_idx;
    logic [OW:0]   scan;
    logic          acc;
    logic          end_beat;
    logic          release_g;

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int CW = (BL > 1) ? $clog2(BL) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    assign end_beat = (cnt_q == CW'(BL - 1)) || I_LAST[owner_q];
`else
    logic unused_last;

    assign unused_last = ^I_LAST;
    assign end_beat    = 1'b1;
`endif

    assign O_BUSY    = (state_q == GRANT);
    assign acc       = O_BUSY && I_REQ[owner_q] && !I_WR_FULL;
    assign release_g = O_BUSY && (!I_REQ[owner_q] || (acc && end_beat));
    assign owner_inc = (owner_q == OW'(NR - 1)) ? '0 : owner_q + 1'b1;

    assign O_GNT     = gnt_q;
    assign O_OWNER   = owner_q;
    assign O_WR_REQ  = acc;
    assign O_WR_DATA = O_BUSY ? I_DATA[owner_q*DW +: DW] : '0;

    always_comb begin
        O_ACK = '0;
        O_ACK[owner_q] = acc;
    end

    // First set request at or above ptr, wrapping past NR-1 back to 0.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = '0;
        for (int k = 0; k < NR; k++) begin
            scan = {1'b0, ptr_q} + (OW+1)'(k);
            if (scan >= (OW+1)'(NR))
                scan = scan - (OW+1)'(NR);
            if (!pick_vld && I_REQ[scan[OW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan[OW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef FIFO_WR_ARB_BURST_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    gnt_d   = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d = pick_idx;
                end
            end
            GRANT: begin
                if (release_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_inc;
`ifdef FIFO_WR_ARB_BURST_EN
                    cnt_d   = '0;
                end else if (acc) begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef FIFO_WR_ARB_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef FIFO_WR_ARB_BURST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule
